// File: rtl/led_pattern_gen.sv
// led_pattern_gen: synchronises and debounces a 3-bit mode selector, adopts a
// new mode only on a step-tick boundary and drives NUM_LEDS outputs with one of
// eight patterns (off, blink, halves, flash, chaser, bounce, count, breathing).
//
// Output timing: state advanced (or reset by a mode change) at a tick edge
// becomes visible in the next cycle, and led is registered from the same
// next-state values, so led, mode_active and the pattern state always change
// together.
module led_pattern_gen #(
   parameter int NUM_LEDS       = 8,
   parameter int TICK_CYCLES    = 1500000,
   parameter int DEB_CYCLES     = 120000,
   parameter int PWM_BITS       = 8,
   parameter bit LED_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2:0]          mode_in,
   output logic [NUM_LEDS-1:0] led,
   output logic                tick,
   output logic [2:0]          mode_active
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [PW-1:0] POS_LAST  = PW'(NUM_LEDS - 1);
   localparam logic [PW-1:0] POS_TURN  = PW'(NUM_LEDS - 2);

   // Breathing ramp: 16 levels from 0 up to full scale minus one step.
   localparam int DUTY_STEP_I = 2 ** (PWM_BITS - 4);
   localparam int DUTY_MAX_I  = (2 ** PWM_BITS) - DUTY_STEP_I;
   localparam logic [PWM_BITS-1:0] DUTY_STEP = PWM_BITS'(DUTY_STEP_I);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(DUTY_MAX_I);

   // Builds the alternating-bit masks used by the blink pattern.
   function automatic logic [NUM_LEDS-1:0] alt_mask(input logic odd);
      logic [NUM_LEDS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         m[i] = (i[0] == odd);
      end
      return m;
   endfunction

   localparam logic [NUM_LEDS-1:0] EVEN_MASK  = alt_mask(1'b0);
   localparam logic [NUM_LEDS-1:0] ODD_MASK   = alt_mask(1'b1);
   localparam logic [NUM_LEDS-1:0] LOWER_MASK = {{(NUM_LEDS/2){1'b0}}, {(NUM_LEDS/2){1'b1}}};
   localparam logic [NUM_LEDS-1:0] UPPER_MASK = ~LOWER_MASK;
   localparam logic [NUM_LEDS-1:0] LED_OFF    = LED_ACTIVE_LOW ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Tick and mode-input front end.
   logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
   logic [2:0]          sync1_q, sync2_q;
   logic [2:0]          cand_q, cand_d;
   logic [DW-1:0]       deb_cnt_q, deb_cnt_d;
   logic [2:0]          mode_pend_q, mode_pend_d;
   logic                tick_s;

   // Pattern state.
   logic [2:0]          mode_active_q, mode_active_d;
   logic                phase_q, phase_d;
   logic [PW-1:0]       pos_q, pos_d;
   logic [PW-1:0]       bpos_q, bpos_d;
   dir_e                bdir_q, bdir_d;
   logic [NUM_LEDS-1:0] count_q, count_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   dir_e                ddir_q, ddir_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [NUM_LEDS-1:0] pat;
   logic [NUM_LEDS-1:0] led_q, led_d;

   assign tick_s      = (tick_cnt_q == TICK_LAST);
   assign tick        = tick_s;
   assign mode_active = mode_active_q;
   assign led         = led_q;

   // Tick counter wrap and debounce: a candidate must hold for DEB_CYCLES
   // before it is copied to the pending mode.
   always_comb begin
      tick_cnt_d  = tick_s ? '0 : tick_cnt_q + 1'b1;
      cand_d      = cand_q;
      deb_cnt_d   = deb_cnt_q;
      mode_pend_d = mode_pend_q;
      if (sync2_q != cand_q) begin
         cand_d    = sync2_q;
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         mode_pend_d = cand_q;
      end else begin
         deb_cnt_d = deb_cnt_q + 1'b1;
      end
   end

   // Pattern state: on a tick either adopt the pending mode (restarting every
   // pattern from its origin) or advance every pattern by one step.
   always_comb begin
      mode_active_d = mode_active_q;
      phase_d       = phase_q;
      pos_d         = pos_q;
      bpos_d        = bpos_q;
      bdir_d        = bdir_q;
      count_d       = count_q;
      duty_d        = duty_q;
      ddir_d        = ddir_q;
      pwm_cnt_d     = pwm_cnt_q + 1'b1;
      if (tick_s) begin
         if (mode_pend_q != mode_active_q) begin
            mode_active_d = mode_pend_q;
            phase_d       = 1'b0;
            pos_d         = '0;
            bpos_d        = '0;
            bdir_d        = DIR_UP;
            count_d       = '0;
            duty_d        = '0;
            ddir_d        = DIR_UP;
         end else begin
            phase_d = ~phase_q;
            pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            count_d = count_q + 1'b1;
            // Bounce: each endpoint is shown once, then the walk turns.
            if (bdir_q == DIR_UP) begin
               if (bpos_q == POS_LAST) begin
                  bpos_d = POS_TURN;
                  bdir_d = DIR_DOWN;
               end else begin
                  bpos_d = bpos_q + 1'b1;
               end
            end else begin
               if (bpos_q == '0) begin
                  bpos_d = PW'(1);
                  bdir_d = DIR_UP;
               end else begin
                  bpos_d = bpos_q - 1'b1;
               end
            end
            // Breathing: triangle ramp that reverses at both endpoints.
            if (ddir_q == DIR_UP) begin
               if (duty_q == DUTY_MAX) begin
                  duty_d = duty_q - DUTY_STEP;
                  ddir_d = DIR_DOWN;
               end else begin
                  duty_d = duty_q + DUTY_STEP;
               end
            end else begin
               if (duty_q == '0) begin
                  duty_d = DUTY_STEP;
                  ddir_d = DIR_UP;
               end else begin
                  duty_d = duty_q - DUTY_STEP;
               end
            end
         end
      end
   end

   // Logical pattern (1 = lit) from next-state values, then output polarity.
   always_comb begin
      pat = '0;
      case (mode_active_d)
         3'd0: pat = '0;
         3'd1: pat = phase_d ? ODD_MASK : EVEN_MASK;
         3'd2: pat = phase_d ? UPPER_MASK : LOWER_MASK;
         3'd3: pat = phase_d ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};
         3'd4: pat = NUM_LEDS'(1) << pos_d;
         3'd5: pat = NUM_LEDS'(1) << bpos_d;
         3'd6: pat = count_d;
         3'd7: pat = {NUM_LEDS{(pwm_cnt_d < duty_d)}};
      endcase
      led_d = LED_ACTIVE_LOW ? ~pat : pat;
   end

   // All state registers; reset clears everything including any pending mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q    <= '0;
         sync1_q       <= '0;
         sync2_q       <= '0;
         cand_q        <= '0;
         deb_cnt_q     <= '0;
         mode_pend_q   <= '0;
         mode_active_q <= '0;
         phase_q       <= 1'b0;
         pos_q         <= '0;
         bpos_q        <= '0;
         bdir_q        <= DIR_UP;
         count_q       <= '0;
         duty_q        <= '0;
         ddir_q        <= DIR_UP;
         pwm_cnt_q     <= '0;
         led_q         <= LED_OFF;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         sync1_q       <= mode_in;
         sync2_q       <= sync1_q;
         cand_q        <= cand_d;
         deb_cnt_q     <= deb_cnt_d;
         mode_pend_q   <= mode_pend_d;
         mode_active_q <= mode_active_d;
         phase_q       <= phase_d;
         pos_q         <= pos_d;
         bpos_q        <= bpos_d;
         bdir_q        <= bdir_d;
         count_q       <= count_d;
         duty_q        <= duty_d;
         ddir_q        <= ddir_d;
         pwm_cnt_q     <= pwm_cnt_d;
         led_q         <= led_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen with small parameters. A step-count reference
// model (closed-form patterns per step since adoption) runs alongside the DUT.
module tb_led_pattern_gen;

   localparam int N_LEDS = 8;
   localparam int TICK   = 4;
   localparam int DEB    = 3;
   localparam int PWMB   = 4;
   localparam bit AL     = 1'b1;

   logic              clk;
   logic              rst;
   logic [2:0]        mode_in;
   logic [N_LEDS-1:0] led;
   logic              tick;
   logic [2:0]        mode_active;

   int n_checks;
   int n_fail;

   // Reference model state.
   int         m_cyc;
   int         m_steps;
   logic [2:0] m_active;
   logic [2:0] m_pend;
   logic       m_tick;
   logic [2:0] in_a, in_b;
   logic [2:0] s2_hist[$];

   led_pattern_gen #(
      .NUM_LEDS(N_LEDS),
      .TICK_CYCLES(TICK),
      .DEB_CYCLES(DEB),
      .PWM_BITS(PWMB),
      .LED_ACTIVE_LOW(AL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mode_in(mode_in),
      .led(led),
      .tick(tick),
      .mode_active(mode_active)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected led for a mode, number of steps since adoption and cycle index.
   function automatic logic [N_LEDS-1:0] model_led(input logic [2:0] md, input int steps, input int cyc);
      logic [N_LEDS-1:0] p;
      int ph, k, idx, lvl;
      p  = '0;
      ph = steps % 2;
      case (md)
         3'd1: for (int i = 0; i < N_LEDS; i++) p[i] = ((i % 2) == ph);
         3'd2: for (int i = 0; i < N_LEDS; i++) p[i] = (ph == 1) ? (i >= N_LEDS / 2) : (i < N_LEDS / 2);
         3'd3: p = (ph == 1) ? {N_LEDS{1'b1}} : {N_LEDS{1'b0}};
         3'd4: p[steps % N_LEDS] = 1'b1;
         3'd5: begin
            k   = steps % (2 * N_LEDS - 2);
            idx = (k < N_LEDS) ? k : (2 * N_LEDS - 2 - k);
            p[idx] = 1'b1;
         end
         3'd6: p = N_LEDS'(steps % (2 ** N_LEDS));
         3'd7: begin
            k   = steps % 30;
            lvl = (k <= 15) ? k : 30 - k;
            if ((cyc % (2 ** PWMB)) < lvl * (2 ** (PWMB - 4))) p = {N_LEDS{1'b1}};
         end
         default: p = '0;
      endcase
      return AL ? ~p : p;
   endfunction

   // Driver: one clock; the model observes the same rst/mode_in the DUT
   // samples at the edge, then control returns at the falling edge.
   task automatic step_clk();
      logic [2:0] s2;
      logic       all_eq;
      @(posedge clk);
      if (rst) begin
         m_cyc    = 0;
         m_steps  = 0;
         m_active = 3'd0;
         m_pend   = 3'd0;
         in_a     = 3'd0;
         in_b     = 3'd0;
         s2_hist.delete();
         s2_hist.push_back(3'd0);
      end else begin
         s2   = in_b;
         in_b = in_a;
         in_a = mode_in;
         if ((m_cyc % TICK) == TICK - 1) begin
            if (m_pend != m_active) begin
               m_active = m_pend;
               m_steps  = 0;
            end else begin
               m_steps++;
            end
         end
         s2_hist.push_back(s2);
         if (s2_hist.size() > DEB + 1) void'(s2_hist.pop_front());
         if (s2_hist.size() == DEB + 1) begin
            all_eq = 1'b1;
            foreach (s2_hist[i]) if (s2_hist[i] != s2) all_eq = 1'b0;
            if (all_eq) m_pend = s2;
         end
         m_cyc++;
      end
      m_tick = ((m_cyc % TICK) == TICK - 1);
      @(negedge clk);
   endtask

   // Steps until mode_active shows target, within a fixed cycle budget.
   task automatic wait_mode(input logic [2:0] target, output bit found);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step_clk();
         if (mode_active == target) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      mode_in = 3'd3;
      rst     = 1'b1;
      repeat (2) step_clk();
      n_checks++;
      if (led !== 8'hFF || mode_active !== 3'd0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: led=%h mode=%0d tick=%b, want led=ff mode=0 tick=0", led, mode_active, tick);
      end
      rst = 1'b0;
      for (int i = 1; i < 8; i++) begin
         step_clk();
         n_checks++;
         if (led !== 8'hFF || tick !== ((i % TICK) == TICK - 1)) begin
            n_fail++;
            $display("FAIL reset_tick cyc=%0d: led=%h tick=%b, want led=ff tick=%b", i, led, tick, (i % TICK) == TICK - 1);
         end
      end
   endtask

   task automatic test_chaser();
      bit found;
      logic [N_LEDS-1:0] one_v, exp_l;
      one_v   = 1;
      mode_in = 3'd4;
      wait_mode(3'd4, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL chaser_adopt: mode=%0d, want 4 within budget", mode_active);
      end
      for (int i = 0; i <= N_LEDS; i++) begin
         if (i > 0) repeat (TICK) step_clk();
         exp_l = ~(one_v << (i % N_LEDS));
         n_checks++;
         if (led !== exp_l || mode_active !== 3'd4) begin
            n_fail++;
            $display("FAIL chaser step=%0d: led=%h mode=%0d, want led=%h mode=4", i, led, mode_active, exp_l);
         end
      end
   endtask

   task automatic test_glitch();
      bit found;
      int len;
      logic [N_LEDS-1:0] exp_l;
      mode_in = 3'd0;
      wait_mode(3'd0, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL glitch_settle: mode=%0d, want 0 within budget", mode_active);
      end
      repeat (10) step_clk();
      // Two-cycle pulse: must never be adopted.
      mode_in = 3'd6;
      repeat (2) step_clk();
      mode_in = 3'd0;
      for (int i = 0; i < 20; i++) begin
         step_clk();
         n_checks++;
         if (led !== 8'hFF || mode_active !== 3'd0) begin
            n_fail++;
            $display("FAIL glitch_short cyc=%0d: led=%h mode=%0d, want led=ff mode=0", i, led, mode_active);
         end
      end
      // Random pulse lengths around the debounce threshold.
      for (int k = 0; k < 8; k++) begin
         len     = $urandom_range(1, 6);
         mode_in = 3'($urandom_range(1, 7));
         repeat (len) step_clk();
         mode_in = 3'd0;
         for (int i = 0; i < 16; i++) begin
            step_clk();
            exp_l = model_led(m_active, m_steps, m_cyc);
            n_checks++;
            if (led !== exp_l || mode_active !== m_active || tick !== m_tick) begin
               n_fail++;
               $display("FAIL glitch_rand len=%0d: led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                        len, led, mode_active, tick, exp_l, m_active, m_tick);
            end
         end
      end
   endtask

   task automatic test_bounce();
      bit found;
      int idx_tab[16];
      logic [N_LEDS-1:0] one_v, exp_l;
      idx_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
      one_v   = 1;
      mode_in = 3'd5;
      wait_mode(3'd5, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL bounce_adopt: mode=%0d, want 5 within budget", mode_active);
      end
      for (int i = 0; i < 16; i++) begin
         if (i > 0) repeat (TICK) step_clk();
         exp_l = ~(one_v << idx_tab[i]);
         n_checks++;
         if (led !== exp_l) begin
            n_fail++;
            $display("FAIL bounce step=%0d: led=%h, want %h", i, led, exp_l);
         end
      end
   endtask

   task automatic test_count_switch();
      bit found;
      logic [N_LEDS-1:0] exp_l;
      mode_in = 3'd6;
      wait_mode(3'd6, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL count_adopt: mode=%0d, want 6 within budget", mode_active);
      end
      for (int i = 0; i <= 256; i++) begin
         if (i > 0) repeat (TICK) step_clk();
         exp_l = ~N_LEDS'(i % 256);
         n_checks++;
         if (led !== exp_l) begin
            n_fail++;
            $display("FAIL count step=%0d: led=%h, want %h", i, led, exp_l);
         end
      end
      mode_in = 3'd1;
      wait_mode(3'd1, found);
      n_checks++;
      if (!found || led !== 8'hAA) begin
         n_fail++;
         $display("FAIL switch_blink_first: led=%h mode=%0d, want led=aa mode=1", led, mode_active);
      end
      repeat (TICK) step_clk();
      n_checks++;
      if (led !== 8'h55) begin
         n_fail++;
         $display("FAIL switch_blink_second: led=%h, want 55", led);
      end
   endtask

   task automatic test_breathing_reset();
      bit found;
      logic [N_LEDS-1:0] exp_l;
      mode_in = 3'd7;
      wait_mode(3'd7, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL breath_adopt: mode=%0d, want 7 within budget", mode_active);
      end
      for (int i = 0; i < 40 * TICK; i++) begin
         step_clk();
         exp_l = model_led(m_active, m_steps, m_cyc);
         n_checks++;
         if (led !== exp_l || mode_active !== m_active || tick !== m_tick) begin
            n_fail++;
            $display("FAIL breath cyc=%0d: led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                     i, led, mode_active, tick, exp_l, m_active, m_tick);
         end
      end
      // Reset in the middle of the ramp.
      repeat (6) step_clk();
      rst = 1'b1;
      step_clk();
      rst = 1'b0;
      n_checks++;
      if (led !== 8'hFF || mode_active !== 3'd0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL breath_reset: led=%h mode=%0d tick=%b, want led=ff mode=0 tick=0", led, mode_active, tick);
      end
      // Re-adopted breathing must start from duty 0, i.e. fully off for a step.
      wait_mode(3'd7, found);
      for (int i = 0; i < TICK; i++) begin
         if (i > 0) step_clk();
         n_checks++;
         if (!found || led !== 8'hFF) begin
            n_fail++;
            $display("FAIL breath_duty0 cyc=%0d: led=%h mode=%0d, want led=ff mode=7", i, led, mode_active);
         end
      end
   endtask

   task automatic test_random();
      int hold;
      logic [N_LEDS-1:0] exp_l;
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            step_clk();
            rst = 1'b0;
         end
         mode_in = 3'($urandom_range(0, 7));
         hold    = $urandom_range(1, 30);
         for (int i = 0; i < hold; i++) begin
            step_clk();
            exp_l = model_led(m_active, m_steps, m_cyc);
            n_checks++;
            if (led !== exp_l || mode_active !== m_active || tick !== m_tick) begin
               n_fail++;
               $display("FAIL random k=%0d: led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                        k, led, mode_active, tick, exp_l, m_active, m_tick);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      mode_in  = 3'd0;
      test_reset();
      test_chaser();
      test_glitch();
      test_bounce();
      test_count_switch();
      test_breathing_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
